eth_transmitter: RTL and testbench
==================================

ETH_TRANSMITTER -- requirements
Module: eth_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per sck half-period; legal range 1..255.
REQ-002 Parameter MIN_LEN, default 60: minimum transmitted frame length in bytes; shorter frames are zero-padded.
REQ-003 Parameter GAP, default 4: clk cycles n_ss held high after a frame before the next start is accepted.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  frame request; sampled on clk.
REQ-007 len  in  11  frame length in bytes; sampled together with start.
REQ-008 busy  out  1  high from the cycle after an accepted start until the GAP period ends.
REQ-009 done  out  1  one-cycle pulse in the cycle n_ss returns high.
REQ-010 tx_byte_cnt  out  11  transmit buffer read address.
REQ-011 tx_d  in  8  transmit buffer data; synchronous RAM, valid one clk after tx_byte_cnt changes.
REQ-012 sck  out  1  serial clock to the receiving side; receiver samples mosi on sck rising edge.
REQ-013 mosi  out  1  serial data, LSB of each byte first.
REQ-014 n_ss  out  1  active-low frame select; low for the whole frame.

Function
REQ-015 States: IDLE, LOAD, SHIFT, TAIL, WAIT_GAP; from reset the FSM is in IDLE.
REQ-016 start is accepted only in IDLE with 1 <= len <= 1536; otherwise it is ignored, busy stays 0.
REQ-017 On acceptance, len is latched; eff_len = max(len, MIN_LEN); later changes of len or start do not affect the frame.
REQ-018 Cycle T start accepted -> T+1: state LOAD, busy=1, n_ss=0, tx_byte_cnt=0, sck=0.
REQ-019 T+2: shift register loaded from tx_d, mosi=bit 0, state SHIFT, tx_byte_cnt increments to 1.
REQ-020 Per bit: mosi stable, sck low CLK_DIV cycles, then sck high CLK_DIV cycles; mosi changes only on the edge where sck falls.
REQ-021 Each byte is 8 bits, LSB first, 16*CLK_DIV clk cycles; no gap between consecutive bytes.
REQ-022 When sck falls after bit 7 of byte k (k < eff_len-1), byte k+1 is loaded from tx_d and tx_byte_cnt increments; tx_byte_cnt never exceeds eff_len.
REQ-023 Byte index k >= latched len is transmitted as 0x00 regardless of tx_d.
REQ-024 After bit 7 of byte eff_len-1: sck falls, state TAIL holds sck=0, n_ss=0 for CLK_DIV cycles.
REQ-025 TAIL end: n_ss=1, done=1 for exactly one cycle, state WAIT_GAP.
REQ-026 WAIT_GAP lasts GAP cycles with busy=1, then IDLE, busy=0; start during busy is ignored, not queued.
REQ-027 Total sck rising edges per frame equal 8*eff_len exactly.
REQ-028 In IDLE and WAIT_GAP, sck=0 and mosi=0.

Reset
REQ-029 n_rst low forces immediately, without clk: IDLE, busy=0, done=0, n_ss=1, sck=0, mosi=0, tx_byte_cnt=0, shift register and bit/byte/divider counters 0.
REQ-030 Reset asserted mid-frame aborts the frame; no done pulse; the first start after n_rst release is accepted normally.

Verification
REQ-031 Reset: n_rst=0 mid-frame -> same time step n_ss=1, sck=0, busy=0; after release outputs stay at REQ-029 values until start.
REQ-032 CLK_DIV=2, len=64, buffer[i]=i -> 512 sck rising edges, decoded LSB-first bytes 0x00..0x3F, n_ss low throughout, one done pulse, byte duration 32 clk.
REQ-033 len=3, buffer 0xAA,0xBB,0xCC,0x77... -> 60 bytes: AA BB CC then 57 x 0x00; tx_byte_cnt peaks at 60.
REQ-034 len=0, len=1537, and start while busy -> no frame, n_ss stays as before, busy unchanged, no done.
REQ-035 Loopback into eth_receiver (n_ss, sck, mosi connected), len=20 with MAC FF:FF:FF:FF:FF:FF -> receiver writes 60 bytes matching the buffer padded with 0x00, recv_byte_cnt sequence 0..59.
REQ-036 Back-to-back: start held high continuously, len=60 -> frames separated by n_ss high for exactly GAP+1 cycles, each frame identical.

Source files
------------

// File: rtl/eth_transmitter.sv
// Serial frame transmitter: reads bytes from a synchronous transmit buffer and
// shifts them out LSB first on sck/mosi under an active-low frame select,
// zero-padding short frames up to MIN_LEN bytes and enforcing an idle gap.
module eth_transmitter #(
    parameter int CLK_DIV = 2,   // clk cycles per sck half-period (1..255)
    parameter int MIN_LEN = 60,  // minimum transmitted frame length in bytes
    parameter int GAP     = 4    // idle clk cycles after a frame (>= 1)
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [10:0] len,
    output logic        busy,
    output logic        done,
    output logic [10:0] tx_byte_cnt,
    input  logic [7:0]  tx_d,
    output logic        sck,
    output logic        mosi,
    output logic        n_ss
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TAIL, WAIT_GAP} state_t;

    localparam logic [10:0] MAX_LEN   = 11'd1536;
    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [10:0] eff_len_q, eff_len_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] gap_q, gap_d;
    logic        sck_q, sck_d;
    logic        nss_q, nss_d;
    logic        done_q, done_d;
    logic        div_end;
    logic [7:0]  next_byte;

    // mosi is taken straight from the shift register; it is cleared whenever
    // the frame is not shifting so the line idles low.
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign tx_byte_cnt = byte_cnt_q;
    assign sck         = sck_q;
    assign mosi        = shift_q[0];
    assign n_ss        = nss_q;

    // Next-state, counters and output register values.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        eff_len_d  = eff_len_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sck_d      = sck_q;
        nss_d      = nss_q;
        done_d     = 1'b0;

        div_end   = (div_q == DIV_LAST);
        // byte_cnt_q is the index of the byte about to be loaded
        next_byte = (byte_cnt_q >= len_q) ? '0 : tx_d;

        case (state_q)
            IDLE: begin
                if (start && (len != '0) && (len <= MAX_LEN)) begin
                    state_d    = LOAD;
                    len_d      = len;
                    eff_len_d  = (len < MIN_LEN_W) ? MIN_LEN_W : len;
                    byte_cnt_d = '0;
                    nss_d      = 1'b0;
                    sck_d      = 1'b0;
                    div_d      = '0;
                    bit_d      = '0;
                end
            end
            LOAD: begin
                shift_d    = next_byte;
                byte_cnt_d = byte_cnt_q + 11'd1;
                bit_d      = '0;
                div_d      = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = shift_q >> 1;
                        end else if (byte_cnt_q == eff_len_q) begin
                            state_d = TAIL;
                            shift_d = '0;
                            bit_d   = '0;
                        end else begin
                            shift_d    = next_byte;
                            byte_cnt_d = byte_cnt_q + 11'd1;
                            bit_d      = '0;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            TAIL: begin
                if (div_end) begin
                    state_d    = WAIT_GAP;
                    nss_d      = 1'b1;
                    done_d     = 1'b1;
                    byte_cnt_d = '0;
                    div_d      = '0;
                    gap_d      = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            WAIT_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            eff_len_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            sck_q      <= 1'b0;
            nss_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            eff_len_q  <= eff_len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sck_q      <= sck_d;
            nss_q      <= nss_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_eth_transmitter.sv
// Self-checking bench for eth_transmitter: frames are decoded from the serial
// lines and compared with bytes predicted from the buffer contents and length.
module tb_eth_transmitter;

    localparam int CLK_DIV = 2;
    localparam int MIN_LEN = 60;
    localparam int GAP     = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [10:0] tx_byte_cnt;
    logic [7:0]  tx_d;
    logic        sck;
    logic        mosi;
    logic        n_ss;

    logic [7:0] mem [0:2047];

    int tests = 0;
    int fails = 0;

    // observations gathered from the serial side
    int   rises, nss_low, done_cnt, peak, glitches, hi_run;
    logic bits[$];
    int   hi_runs[$];
    logic prev_sck, prev_mosi;

    eth_transmitter #(
        .CLK_DIV(CLK_DIV),
        .MIN_LEN(MIN_LEN),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .tx_byte_cnt(tx_byte_cnt),
        .tx_d       (tx_d),
        .sck        (sck),
        .mosi       (mosi),
        .n_ss       (n_ss)
    );

    always #5 clk = ~clk;

    // transmit buffer: synchronous read
    always @(posedge clk) tx_d <= mem[tx_byte_cnt];

    // serial-side observer, sampling between active edges
    initial begin
        prev_sck  = 1'b0;
        prev_mosi = 1'b0;
        forever begin
            @(negedge clk);
            if (n_ss === 1'b0) begin
                nss_low++;
                if (hi_run > 0) begin
                    hi_runs.push_back(hi_run);
                    hi_run = 0;
                end
                if (sck === 1'b1 && prev_sck === 1'b0) begin
                    rises++;
                    bits.push_back(mosi);
                end
                if ((sck === 1'b1 || prev_sck === 1'b1) &&
                    !(prev_sck === 1'b1 && sck === 1'b0) && mosi !== prev_mosi)
                    glitches++;
            end else begin
                hi_run++;
            end
            if (done === 1'b1) done_cnt++;
            if (int'(tx_byte_cnt) > peak) peak = int'(tx_byte_cnt);
            prev_sck  = sck;
            prev_mosi = mosi;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rises    = 0;
        nss_low  = 0;
        done_cnt = 0;
        peak     = 0;
        glitches = 0;
        hi_run   = 0;
        bits.delete();
        hi_runs.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    endtask

    function automatic int eff_of(input int l);
        return (l < MIN_LEN) ? MIN_LEN : l;
    endfunction

    // count bytes of one decoded frame that differ from the padded buffer
    function automatic int count_bad(input int l, input int base);
        int         bad;
        logic [7:0] got, want;
        bad = 0;
        for (int k = 0; k < eff_of(l); k++) begin
            want = (k < l) ? mem[k] : 8'h00;
            got  = '0;
            for (int b = 0; b < 8; b++) begin
                if (base + 8 * k + b < bits.size()) got[b] = bits[base + 8 * k + b];
                else got[b] = 1'bx;
            end
            if (got !== want) bad++;
        end
        return bad;
    endfunction

    task automatic send_frame(input int l, input bit poke);
        int eff, limit, cyc;
        eff = eff_of(l);
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'(l);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 11'($urandom_range(1, 1536));
        chk("busy_on_accept", 32'(busy), 32'd1);
        chk("nss_on_accept", 32'(n_ss), 32'd0);
        chk("cnt_on_accept", 32'(tx_byte_cnt), 32'd0);
        limit = 16 * CLK_DIV * eff + CLK_DIV + GAP + 20;
        cyc   = 0;
        while (busy === 1'b1 && cyc < limit) begin
            if (poke && cyc == 40) begin
                start = 1'b1;
                len   = 11'd5;
            end
            if (poke && cyc == 42) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_timeout", 32'(cyc < limit), 32'd1);
        repeat (GAP + 3) @(posedge clk);
        #1;
        chk("idle_busy_after", 32'(busy), 32'd0);
        chk("idle_nss_after", 32'(n_ss), 32'd1);
        chk("sck_rises", 32'(rises), 32'(8 * eff));
        chk("bytes_bad", 32'(count_bad(l, 0)), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("cnt_peak", 32'(peak), 32'(eff));
        chk("nss_low_cycles", 32'(nss_low), 32'(1 + 16 * CLK_DIV * eff + CLK_DIV));
        chk("mosi_stable", 32'(glitches), 32'd0);
    endtask

    task automatic try_invalid(input int l);
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'(l);
        @(posedge clk); #1;
        start = 1'b0;
        chk("invalid_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("invalid_nss", 32'(n_ss), 32'd1);
        chk("invalid_done", 32'(done_cnt), 32'd0);
        chk("invalid_nss_low", 32'(nss_low), 32'd0);
    endtask

    initial begin
        int l, cyc;
        n_rst = 1'b0;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        clear_stats();

        // reset values
        #12;
        chk("rst_nss", 32'(n_ss), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(tx_byte_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_nss", 32'(n_ss), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // incrementing buffer, 64 bytes
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        send_frame(64, 1'b0);

        // short frame padded to MIN_LEN
        for (int i = 0; i < 2048; i++) mem[i] = 8'h77;
        mem[0] = 8'hAA;
        mem[1] = 8'hBB;
        mem[2] = 8'hCC;
        send_frame(3, 1'b0);

        // length boundaries; start while busy must be dropped
        fill_random();
        send_frame(1, 1'b0);
        fill_random();
        send_frame(60, 1'b1);
        fill_random();
        send_frame(61, 1'b0);

        // rejected lengths
        try_invalid(0);
        try_invalid(1537);

        // random lengths and contents
        for (int n = 0; n < 4; n++) begin
            fill_random();
            l = int'($urandom_range(1, 130));
            send_frame(l, 1'b0);
        end

        // back-to-back frames with start held high
        fill_random();
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'd60;
        cyc   = 0;
        while (done_cnt < 2 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("b2b_timeout", 32'(cyc < 5000), 32'd1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_done", 32'(done_cnt), 32'd2);
        chk("b2b_rises", 32'(rises), 32'(2 * 8 * 60));
        chk("b2b_frame0", 32'(count_bad(60, 0)), 32'd0);
        chk("b2b_frame1", 32'(count_bad(60, 8 * 60)), 32'd0);
        chk("b2b_gap", (hi_runs.size() >= 2) ? 32'(hi_runs[1]) : 32'hFFFF_FFFF, 32'(GAP + 1));

        // reset in the middle of a long frame
        fill_random();
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'd1536;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("abort_nss", 32'(n_ss), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_cnt", 32'(tx_byte_cnt), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_idle_nss", 32'(n_ss), 32'd1);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        fill_random();
        send_frame(int'($urandom_range(1, 80)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
